// File: rtl/ped_signal_driver.sv
// Pedestrian lamp / countdown driver slaved to a car-light controller's state code.
// Optional macro PED_COUNTDOWN_EN enables the two-digit seven-segment countdown.
module ped_signal_driver #(
  parameter int CLK_HZ       = 50000000,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int RED_S        = 41,
  parameter int BLINK_S      = 5
) (
  input  logic       clk,
  input  logic       res,
  input  logic [1:0] light_state,
  input  logic       btn,
  output logic       btn_req,
  output logic       car_red,
  output logic       car_yellow,
  output logic       car_green,
  output logic       ped_red,
  output logic       ped_green,
  output logic       wait_lamp,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_units
);

  localparam int DIV_W = $clog2(CLK_HZ + 1);
  localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);

  localparam logic [1:0] ST_RED    = 2'd0;
  localparam logic [1:0] ST_GREEN  = 2'd1;
  localparam logic [1:0] ST_YELLOW = 2'd2;
  localparam logic [1:0] ST_FAULT  = 2'd3;

  logic [1:0]       state_reg, state_next;
  logic [DIV_W-1:0] cnt_reg, cnt_next;
  logic             phase_reg, phase_next;
  logic [6:0]       sec_reg, sec_next;
  logic             sync1_reg, sync2_reg;
  logic [DB_W-1:0]  db_cnt_reg, db_cnt_next;
  logic             btn_req_reg, btn_req_next;
  logic             btn_req_d_reg;
  logic             wait_reg, wait_next;

  logic tick, half_tick, state_chg, enter_red, btn_rise;

  // State register: reset parks in RED so a release with RED held does not restart the walk.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_reg <= ST_RED;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = light_state;
  end

  assign state_chg = (state_next != state_reg);
  assign enter_red = state_chg && (state_next == ST_RED);
  assign tick      = (cnt_reg == DIV_W'(CLK_HZ - 1));
  assign half_tick = tick || (cnt_reg == DIV_W'(CLK_HZ / 2 - 1));
  assign btn_rise  = btn_req_reg && !btn_req_d_reg;

  always_comb begin
    cnt_next     = state_chg ? '0 : (tick ? '0 : cnt_reg + 1'b1);
    phase_next   = state_chg ? 1'b1 : (half_tick ? ~phase_reg : phase_reg);
    sec_next     = sec_reg;
    if (enter_red) begin
      sec_next = 7'(RED_S);
    end else if (state_next != ST_RED) begin
      sec_next = '0;
    end else if (tick && sec_reg != 7'd0) begin
      sec_next = sec_reg - 7'd1;
    end
    db_cnt_next  = '0;
    btn_req_next = btn_req_reg;
    // Any sample equal to the accepted level restarts the stability count.
    if (sync2_reg != btn_req_reg) begin
      if (db_cnt_reg == DB_W'(DEBOUNCE_CYC - 1)) begin
        btn_req_next = sync2_reg;
      end else begin
        db_cnt_next = db_cnt_reg + 1'b1;
      end
    end
    wait_next = wait_reg;
    if (enter_red) begin
      wait_next = 1'b0;
    end else if (btn_rise && state_reg != ST_RED) begin
      wait_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cnt_reg       <= '0;
      phase_reg     <= 1'b1;
      sec_reg       <= '0;
      sync1_reg     <= 1'b0;
      sync2_reg     <= 1'b0;
      db_cnt_reg    <= '0;
      btn_req_reg   <= 1'b0;
      btn_req_d_reg <= 1'b0;
      wait_reg      <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      phase_reg     <= phase_next;
      sec_reg       <= sec_next;
      sync1_reg     <= btn;
      sync2_reg     <= sync1_reg;
      db_cnt_reg    <= db_cnt_next;
      btn_req_reg   <= btn_req_next;
      btn_req_d_reg <= btn_req_reg;
      wait_reg      <= wait_next;
    end
  end

  assign btn_req = btn_req_reg;

`ifdef PED_COUNTDOWN_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  logic [6:0] tens_val, units_val;
  assign tens_val  = sec_reg / 7'd10;
  assign units_val = sec_reg - tens_val * 7'd10;
`endif

  always_comb begin
    car_red    = 1'b0;
    car_yellow = 1'b0;
    car_green  = 1'b0;
    ped_red    = 1'b1;
    ped_green  = 1'b0;
    wait_lamp  = wait_reg;
    seg_tens   = 7'h7F;
    seg_units  = 7'h7F;
    case (state_reg)
      ST_RED: begin
        car_red = 1'b1;
        if (sec_reg != 7'd0) begin
          ped_red   = 1'b0;
          ped_green = (sec_reg > 7'(BLINK_S)) ? 1'b1 : phase_reg;
`ifdef PED_COUNTDOWN_EN
          seg_units = seg7(units_val[3:0]);
          seg_tens  = (tens_val == 7'd0) ? 7'h7F : seg7(tens_val[3:0]);
`endif
        end
      end
      ST_GREEN:  car_green  = 1'b1;
      ST_YELLOW: car_yellow = 1'b1;
      ST_FAULT: begin
        car_yellow = phase_reg;
        wait_lamp  = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ped_signal_driver.sv
// Scoreboard bench for ped_signal_driver: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_ped_signal_driver;

  logic       clk = 1'b0;
  logic       res;
  logic [1:0] light_state;
  logic       btn;
  logic       btn_req, car_red, car_yellow, car_green, ped_red, ped_green, wait_lamp;
  logic [6:0] seg_tens, seg_units;

  ped_signal_driver #(
    .CLK_HZ(10), .DEBOUNCE_CYC(4), .RED_S(12), .BLINK_S(3)
  ) dut (
    .clk(clk), .res(res), .light_state(light_state), .btn(btn),
    .btn_req(btn_req), .car_red(car_red), .car_yellow(car_yellow),
    .car_green(car_green), .ped_red(ped_red), .ped_green(ped_green),
    .wait_lamp(wait_lamp), .seg_tens(seg_tens), .seg_units(seg_units)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at_cyc;
    string      name;
    logic [6:0] lamps;
    logic [6:0] tens;
    logic [6:0] units;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  // Lamp vector order: {car_red, car_yellow, car_green, ped_red, ped_green, wait_lamp, btn_req}
  localparam logic [6:0] L_RST   = 7'b1001000;
  localparam logic [6:0] L_GRN   = 7'b0011000;
  localparam logic [6:0] L_WALK  = 7'b1000100;
  localparam logic [6:0] L_BOFF  = 7'b1000000;
  localparam logic [6:0] L_YEL   = 7'b0101000;
  localparam logic [6:0] L_FOFF  = 7'b0001000;
  localparam logic [6:0] BL      = 7'h7F;

  function automatic logic [6:0] cd(input logic [6:0] v);
`ifdef PED_COUNTDOWN_EN
    return v;
`else
    return 7'h7F;
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int d, input string nm, input logic [6:0] l,
                           input logic [6:0] t, input logic [6:0] u);
    exp_t e;
    e.at_cyc = cyc + d;
    e.name   = nm;
    e.lamps  = l;
    e.tens   = t;
    e.units  = u;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t       e;
    logic [6:0] act;
    act = {car_red, car_yellow, car_green, ped_red, ped_green, wait_lamp, btn_req};
    while (sb.size() > 0 && sb[0].at_cyc <= cyc) begin
      e = sb.pop_front();
      total++;
      if (e.at_cyc < cyc) begin
        bad++;
        $display("FAIL %s: check for cycle %0d missed (now %0d)", e.name, e.at_cyc, cyc);
      end else if (act !== e.lamps || seg_tens !== e.tens || seg_units !== e.units) begin
        bad++;
        $display("FAIL %s @%0d: lamps=%b tens=%h units=%h, expected lamps=%b tens=%h units=%h",
                 e.name, cyc, act, seg_tens, seg_units, e.lamps, e.tens, e.units);
      end else begin
        $display("ok   %s @%0d: lamps=%b tens=%h units=%h", e.name, cyc, act, seg_tens, seg_units);
      end
    end
  end

  initial begin
    res = 1'b0;
    light_state = 2'd1;
    btn = 1'b0;
    step(2);
    expect_at(0, "reset", L_RST, BL, BL);
    res = 1'b1;
    expect_at(1, "green", L_GRN, BL, BL);
    step(3);

    // Walk phase from GREEN->RED, through blink and expiry
    light_state = 2'd0;
    expect_at(1,   "walk12",     L_WALK, cd(7'h79), cd(7'h24));
    expect_at(90,  "walk04",     L_WALK, BL, cd(7'h19));
    expect_at(91,  "walk03",     L_WALK, BL, cd(7'h30));
    expect_at(95,  "blink_on",   L_WALK, BL, cd(7'h30));
    expect_at(96,  "blink_off",  L_BOFF, BL, cd(7'h30));
    expect_at(100, "blink_off2", L_BOFF, BL, cd(7'h30));
    expect_at(101, "walk02",     L_WALK, BL, cd(7'h24));
    expect_at(120, "walk01_off", L_BOFF, BL, cd(7'h79));
    expect_at(121, "walk_done",  L_RST, BL, BL);
    expect_at(131, "red_hold",   L_RST, BL, BL);
    step(131);
    light_state = 2'd1;
    expect_at(1, "green2", L_GRN, BL, BL);
    step(2);

    // Bouncing button in GREEN
    btn = 1'b1; step(2);
    btn = 1'b0; step(2);
    btn = 1'b1;
    expect_at(5, "deb_hold", L_GRN, BL, BL);
    expect_at(6, "btn_req",  7'b0011001, BL, BL);
    expect_at(7, "wait_on",  7'b0011011, BL, BL);
    step(8);
    light_state = 2'd0;
    expect_at(1,  "red_clr_wait", 7'b1000101, cd(7'h79), cd(7'h24));
    expect_at(51, "sec7",         7'b1000101, BL, cd(7'h78));
    step(53);

    // Asynchronous reset mid-walk, RED held across release
    res = 1'b0;
    btn = 1'b0;
    expect_at(0, "async_rst", L_RST, BL, BL);
    step(2);
    res = 1'b1;
    expect_at(1,  "no_restart",  L_RST, BL, BL);
    expect_at(15, "no_restart2", L_RST, BL, BL);
    step(15);
    light_state = 2'd1;
    expect_at(1, "green3", L_GRN, BL, BL);
    step(3);
    light_state = 2'd0;
    expect_at(1, "walk12b", L_WALK, cd(7'h79), cd(7'h24));
    step(4);

    // Early switch out of RED
    light_state = 2'd2;
    expect_at(0, "pre_early",    L_WALK, cd(7'h79), cd(7'h24));
    expect_at(1, "early_yellow", L_YEL, BL, BL);
    step(3);

    // Fault code: blinking yellow
    light_state = 2'd3;
    expect_at(1,  "fault_on",   L_YEL,  BL, BL);
    expect_at(5,  "fault_on2",  L_YEL,  BL, BL);
    expect_at(6,  "fault_off",  L_FOFF, BL, BL);
    expect_at(10, "fault_off2", L_FOFF, BL, BL);
    expect_at(11, "fault_on3",  L_YEL,  BL, BL);
    step(12);

    for (int i = 0; i < 50 && sb.size() > 0; i++) step(1);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL %s: never checked (due cycle %0d, now %0d)", e.name, e.at_cyc, cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ped_signal_driver.md
PED_SIGNAL_DRIVER -- requirements
Module: ped_signal_driver

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000: clk cycles per 1 s tick.
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 500000: consecutive stable synchronized samples needed to accept a btn level.
REQ-003 SHALL have parameter RED_S, default 41: pedestrian walk seconds loaded on car RED entry (range 1..99).
REQ-004 SHALL have parameter BLINK_S, default 5: final seconds of walk during which ped_green blinks (less than RED_S).
REQ-005 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-006 SHALL have port res, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port light_state, input, 2 bits: car light code from the controller (0 RED, 1 GREEN, 2 YELLOW, 3 invalid).
REQ-008 SHALL have port btn, input, 1 bit: raw, asynchronous, bouncing pedestrian push button (1 = pressed).
REQ-009 SHALL have port btn_req, output, 1 bit: debounced button level fed back to the controller's btn input.
REQ-010 SHALL have ports car_red, car_yellow and car_green, each output, 1 bit: car lamp drives (1 = lit).
REQ-011 SHALL have ports ped_red and ped_green, each output, 1 bit: pedestrian lamp drives (1 = lit).
REQ-012 SHALL have port wait_lamp, output, 1 bit: request-registered indicator.
REQ-013 SHALL have ports seg_tens and seg_units, each output, 7 bits: countdown digits, active-low segments {g,f,e,d,c,b,a}.

Function
REQ-014 SHALL register light_state once; all decoding uses the registered copy (1-cycle latency).
REQ-015 SHALL generate tick: 1-cycle pulse every CLK_HZ cycles, plus half_tick at CLK_HZ/2; the divider restarts at 0 on every change of registered light_state.
REQ-016 SHALL drive exactly one car lamp for codes 0/1/2 (RED->car_red, GREEN->car_green, YELLOW->car_yellow).
REQ-017 For code 3 (fault), car_red and car_green SHALL be 0 and car_yellow SHALL toggle on every half_tick, starting lit; ped_red=1, ped_green=0, wait_lamp=0, digits blank (7'h7F).
REQ-018 SHALL load sec_left=RED_S on the cycle the registered state becomes RED; decrement on each tick while RED; saturate at 0.
REQ-019 While RED with sec_left>BLINK_S, ped_green=1 and ped_red=0.
REQ-020 While RED with 0<sec_left<=BLINK_S, ped_red=0 and ped_green SHALL toggle on each half_tick, lit for the first half-second.
REQ-021 While RED with sec_left=0, or in GREEN or YELLOW, ped_green=0 and ped_red=1.
REQ-022 btn SHALL pass a 2-flop synchronizer; btn_req changes only after DEBOUNCE_CYC consecutive equal samples differing from it; any bounce restarts the count.
REQ-023 A rising edge of btn_req while not RED SHALL set wait_lamp on the next cycle; entering RED SHALL clear it; presses during RED do not set it.
REQ-024 When the state leaves RED before sec_left reaches 0 (early switch), the countdown SHALL be abandoned and ped_red asserted in the same cycle the new state is registered.

Reset
REQ-025 While res=0: car_red=1 and all other lamps except ped_red =0; ped_red=1; wait_lamp=0; btn_req=0; digits blank; sec_left=0; divider, debounce counter and synchronizer cleared.
REQ-026 Reset asserted mid-walk SHALL take effect immediately; after release the block SHALL restart the countdown only on a new transition into RED.

Configuration
REQ-027 With PED_COUNTDOWN_EN defined, seg_tens/seg_units SHALL show sec_left as two decimal digits while RED and sec_left>0, tens digit blank when <10, and be blank otherwise.
REQ-028 Without PED_COUNTDOWN_EN, both digit outputs SHALL be tied to 7'h7F; sec_left SHALL still be kept for blinking.

Verification (CLK_HZ=10, DEBOUNCE_CYC=4, RED_S=12, BLINK_S=3)
REQ-029 light_state 1->0 -> ped_green=1 after 1 cycle; digits "12"; 90 cycles later "03" and blinking starts with 5-cycle half periods.
REQ-030 Hold RED 130 cycles -> sec_left 0, ped_red=1, digits blank; then switch to 1 -> car_green=1.
REQ-031 In GREEN, btn bounces 1,0,1 every 2 cycles then stays 1 -> btn_req rises 4 cycles after the last edge plus 2 sync cycles; wait_lamp=1; next RED clears it.
REQ-032 light_state=3 -> car_yellow toggles every 5 cycles, ped_red=1, digits 7'h7F.
REQ-033 res=0 at sec_left=7 -> outputs take reset values asynchronously; release with state held at RED -> no countdown until GREEN->RED.
REQ-034 Build without PED_COUNTDOWN_EN; rerun REQ-029 -> digits constant 7'h7F, lamp timing unchanged.
